// File: rtl/score_display.sv
// score_display: converts score/highScore to six BCD digits with a multi-cycle double-dabble engine and drives HEX0..HEX5.
// Build macro SCORE_DISPLAY_LEADING_BLANK_EN blanks leading zero digits on HEX5..HEX1.
module score_display #(
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int REFRESH_HZ      = 20
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic [31:0] score,
    input  logic [31:0] highScore,
    input  logic        showHigh,
    input  logic        forceUpdate,
    output logic [23:0] scoreBCD,
    output logic [23:0] highBCD,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        busy,
    output logic        valid
);
    localparam int PERIOD = CLOCK_FREQUENCY / REFRESH_HZ;
    localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(PERIOD - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_S  = 3'd1;
    localparam logic [2:0] SHIFT_S = 3'd2;
    localparam logic [2:0] LOAD_H  = 3'd3;
    localparam logic [2:0] SHIFT_H = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
    localparam logic [41:0] HEX_RESET = {{5{SEG_BLANK}}, SEG_ZERO};
`else
    localparam logic [41:0] HEX_RESET = {6{SEG_ZERO}};
`endif

    function automatic logic [19:0] saturate(input logic [31:0] v);
        return (v > 32'd999999) ? 20'd999999 : v[19:0];
    endfunction

    function automatic logic [23:0] add3(input logic [23:0] b);
        logic [23:0] r;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              pending_q, pending_d;
    logic [2:0]        state_q, state_d;
    logic [31:0]       score_snap_q, score_snap_d;
    logic [31:0]       high_snap_q, high_snap_d;
    logic [19:0]       bin_q, bin_d;
    logic [23:0]       acc_q, acc_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [23:0]       score_res_q, score_res_d;
    logic [23:0]       score_bcd_q, score_bcd_d;
    logic [23:0]       high_bcd_q, high_bcd_d;
    logic              valid_q, valid_d;
    logic [5:0][6:0]   hex_q, hex_d;

    logic              tick;
    logic              start;
    logic [23:0]       adj;
    logic [23:0]       disp;
`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
    logic              lead;
`endif

    always_comb begin
        tick       = (tick_cnt_q == '0);
        tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - TICK_W'(1);
        start      = pending_q | forceUpdate | tick;

        // Any request seen in IDLE starts a conversion at once; while busy only forceUpdate is remembered.
        pending_d = pending_q;
        if (state_q == IDLE) begin
            pending_d = 1'b0;
        end else if (forceUpdate) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        adj          = add3(acc_q);
        state_d      = state_q;
        score_snap_d = score_snap_q;
        high_snap_d  = high_snap_q;
        bin_d        = bin_q;
        acc_d        = acc_q;
        bit_cnt_d    = bit_cnt_q;
        score_res_d  = score_res_q;
        score_bcd_d  = score_bcd_q;
        high_bcd_d   = high_bcd_q;
        valid_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    score_snap_d = score;
                    high_snap_d  = highScore;
                    state_d      = LOAD_S;
                end
            end
            LOAD_S: begin
                bin_d     = saturate(score_snap_q);
                acc_d     = '0;
                bit_cnt_d = '0;
                state_d   = SHIFT_S;
            end
            SHIFT_S: begin
                {acc_d, bin_d} = {adj[22:0], bin_q, 1'b0};
                bit_cnt_d      = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd19) state_d = LOAD_H;
            end
            LOAD_H: begin
                score_res_d = acc_q;
                bin_d       = saturate(high_snap_q);
                acc_d       = '0;
                bit_cnt_d   = '0;
                state_d     = SHIFT_H;
            end
            SHIFT_H: begin
                {acc_d, bin_d} = {adj[22:0], bin_q, 1'b0};
                bit_cnt_d      = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd19) state_d = DONE;
            end
            DONE: begin
                // Both results land together so neither output ever shows a half-finished value.
                score_bcd_d = score_res_q;
                high_bcd_d  = acc_q;
                valid_d     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        disp = showHigh ? high_bcd_q : score_bcd_q;
        for (int i = 0; i < 6; i++) begin
            hex_d[i] = seg7(disp[4*i +: 4]);
        end
`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
        lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            lead = lead & (disp[4*i +: 4] == 4'd0);
            if (lead) hex_d[i] = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_q   <= TICK_RELOAD;
            pending_q    <= 1'b0;
            state_q      <= IDLE;
            score_snap_q <= '0;
            high_snap_q  <= '0;
            bin_q        <= '0;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            score_res_q  <= '0;
            score_bcd_q  <= '0;
            high_bcd_q   <= '0;
            valid_q      <= 1'b0;
            hex_q        <= HEX_RESET;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            pending_q    <= pending_d;
            state_q      <= state_d;
            score_snap_q <= score_snap_d;
            high_snap_q  <= high_snap_d;
            bin_q        <= bin_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            score_res_q  <= score_res_d;
            score_bcd_q  <= score_bcd_d;
            high_bcd_q   <= high_bcd_d;
            valid_q      <= valid_d;
            hex_q        <= hex_d;
        end
    end

    assign scoreBCD = score_bcd_q;
    assign highBCD  = high_bcd_q;
    assign busy     = (state_q != IDLE);
    assign valid    = valid_q;
    assign HEX0     = hex_q[0];
    assign HEX1     = hex_q[1];
    assign HEX2     = hex_q[2];
    assign HEX3     = hex_q[3];
    assign HEX4     = hex_q[4];
    assign HEX5     = hex_q[5];

endmodule

// File: tb/tb_score_display.sv
`timescale 1ns/1ps
// Bench for score_display: scoreboarded conversions on a slow-tick instance, request-timing checks on a fast-tick instance.
module tb_score_display;
    logic Clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    logic [31:0] score_a = '0;
    logic [31:0] high_a  = '0;
    logic        show_a  = 1'b0;
    logic        force_a = 1'b0;
    logic [23:0] sbcd_a, hbcd_a;
    logic [6:0]  hex0_a, hex1_a, hex2_a, hex3_a, hex4_a, hex5_a;
    logic        busy_a, valid_a;
    logic [41:0] hex_a;
    assign hex_a = {hex5_a, hex4_a, hex3_a, hex2_a, hex1_a, hex0_a};

    logic [31:0] score_b = 32'd777;
    logic [31:0] high_b  = 32'd5000000;
    logic        show_b  = 1'b0;
    logic        force_b = 1'b0;
    logic [23:0] sbcd_b, hbcd_b;
    logic [6:0]  hex0_b, hex1_b, hex2_b, hex3_b, hex4_b, hex5_b;
    logic        busy_b, valid_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [47:0] exp_q[$];
    logic [47:0] exp_item;

    score_display u_dut_a (
        .Clock(Clock), .reset(rst_n), .score(score_a), .highScore(high_a),
        .showHigh(show_a), .forceUpdate(force_a), .scoreBCD(sbcd_a), .highBCD(hbcd_a),
        .HEX0(hex0_a), .HEX1(hex1_a), .HEX2(hex2_a), .HEX3(hex3_a), .HEX4(hex4_a), .HEX5(hex5_a),
        .busy(busy_a), .valid(valid_a)
    );

    score_display #(.CLOCK_FREQUENCY(100), .REFRESH_HZ(10)) u_dut_b (
        .Clock(Clock), .reset(rst_n), .score(score_b), .highScore(high_b),
        .showHigh(show_b), .forceUpdate(force_b), .scoreBCD(sbcd_b), .highBCD(hbcd_b),
        .HEX0(hex0_b), .HEX1(hex1_b), .HEX2(hex2_b), .HEX3(hex3_b), .HEX4(hex4_b), .HEX5(hex5_b),
        .busy(busy_b), .valid(valid_b)
    );

`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
    localparam logic [41:0] HEX_RESET = {{5{7'b1111111}}, 7'b1000000};
`else
    localparam logic [41:0] HEX_RESET = {6{7'b1000000}};
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    function automatic logic [23:0] to_bcd(input logic [31:0] v);
        logic [31:0] x;
        logic [23:0] r;
        x = (v > 32'd999999) ? 32'd999999 : v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] hex_of(input logic [23:0] b);
        logic [41:0] h;
        logic        lead;
        for (int i = 0; i < 6; i++) h[7*i +: 7] = seg_of(b[4*i +: 4]);
`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
        lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (b[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead) h[7*i +: 7] = 7'b1111111;
        end
`else
        lead = 1'b0;
`endif
        return h;
    endfunction

    // Scoreboard: every valid pulse on instance A must match the oldest queued request.
    always @(posedge Clock) begin
        #1;
        if (valid_a) begin
            check("valid_has_expect", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                check("score_bcd", 64'(sbcd_a), 64'(exp_item[47:24]));
                check("high_bcd", 64'(hbcd_a), 64'(exp_item[23:0]));
            end
        end
    end

    task automatic run_conv(input logic [31:0] s, input logic [31:0] h);
        int lat;
        score_a = s;
        high_a  = h;
        force_a = 1'b1;
        exp_q.push_back({to_bcd(s), to_bcd(h)});
        step(1);
        force_a = 1'b0;
        score_a = $urandom;
        high_a  = $urandom;
        check("busy_after_request", 64'(busy_a), 64'd1);
        lat = 1;
        while (!valid_a && lat < 100) begin
            step(1);
            lat++;
        end
        check("valid_latency", 64'(lat), 64'd44);
        check("busy_low_at_valid", 64'(busy_a), 64'd0);
    endtask

    task automatic wait_rise_b(output int w);
        int n;
        n = 0;
        while (busy_b && n < 200) begin step(1); n++; end
        while (!busy_b && n < 200) begin step(1); n++; end
        check("b_busy_rise_seen", 64'(n < 200), 64'd1);
        w = cyc;
    endtask

    logic [31:0] sat_tab [8];

    initial begin
        int t0, n, nv, r0, r1, r2, r3;
        logic [31:0] s1, h1, s2, h2;

        step(3);
        check("reset_busy", 64'(busy_a), 64'd0);
        check("reset_valid", 64'(valid_a), 64'd0);
        check("reset_score_bcd", 64'(sbcd_a), 64'd0);
        check("reset_high_bcd", 64'(hbcd_a), 64'd0);
        check("reset_hex", 64'(hex_a), 64'(HEX_RESET));
        rst_n = 1'b1;
        step(2);

        run_conv(32'd123456, 32'd42);
        step(1);
        check("valid_one_cycle", 64'(valid_a), 64'd0);
        check("hex_score_123456", 64'(hex_a), 64'(hex_of(24'h123456)));
        show_a = 1'b1;
        step(1);
        check("hex_high_42", 64'(hex_a), 64'(hex_of(24'h000042)));
        check("busy_on_select", 64'(busy_a), 64'd0);
        show_a = 1'b0;
        step(1);
        check("hex_back_to_score", 64'(hex_a), 64'(hex_of(24'h123456)));

        sat_tab[0] = 32'd1000000;
        sat_tab[1] = 32'hFFFF_FFFF;
        sat_tab[2] = 32'd999999;
        sat_tab[3] = 32'd0;
        sat_tab[4] = 32'd5;
        for (int i = 5; i < 8; i++) sat_tab[i] = $urandom_range(0, 1200000);
        for (int i = 0; i < 8; i++) begin
            s1 = sat_tab[i];
            h1 = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 999999));
            run_conv(s1, h1);
            step(1);
            check("hex_after_conv", 64'(hex_a), 64'(hex_of(to_bcd(s1))));
            step(2);
        end

        // A second request while busy is held and starts right after the first conversion returns to IDLE.
        s1 = 32'd314159; h1 = 32'd271828;
        s2 = 32'd8080;   h2 = 32'd2000000;
        t0 = cyc;
        score_a = s1; high_a = h1; force_a = 1'b1;
        exp_q.push_back({to_bcd(s1), to_bcd(h1)});
        step(1);
        force_a = 1'b0; score_a = s2; high_a = h2;
        step(9);
        force_a = 1'b1;
        exp_q.push_back({to_bcd(s2), to_bcd(h2)});
        step(1);
        force_a = 1'b0;
        n = 0;
        while (!valid_a && n < 200) begin step(1); n++; end
        check("pend_first_valid", 64'(cyc - t0), 64'd44);
        step(1);
        check("pend_busy_again", 64'(busy_a), 64'd1);
        n = 0;
        while (!valid_a && n < 200) begin step(1); n++; end
        check("pend_second_valid", 64'(cyc - t0), 64'd88);
        step(2);

        score_a = 32'd654321; high_a = 32'd1; force_a = 1'b1;
        step(1);
        force_a = 1'b0;
        step(20);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy_a), 64'd0);
        check("midreset_valid", 64'(valid_a), 64'd0);
        check("midreset_score_bcd", 64'(sbcd_a), 64'd0);
        check("midreset_high_bcd", 64'(hbcd_a), 64'd0);
        check("midreset_hex", 64'(hex_a), 64'(HEX_RESET));
        step(2);
        rst_n = 1'b1;
        nv = 0;
        repeat (60) begin
            step(1);
            if (valid_a) nv++;
        end
        check("no_valid_after_abort", 64'(nv), 64'd0);

        // Instance B ticks every 10 cycles, so ticks always land during a 44-cycle conversion.
        wait_rise_b(r0);
        wait_rise_b(r1);
        check("tick_drop_period", 64'(r1 - r0), 64'd50);
        step(9);
        force_b = 1'b1;
        step(1);
        force_b = 1'b0;
        wait_rise_b(r2);
        check("pending_force_start", 64'(r2 - r1), 64'd44);
        wait_rise_b(r3);
        check("tick_phase_kept", 64'(r3 - r2), 64'd46);
        step(49);
        force_b = 1'b1;
        step(1);
        force_b = 1'b0;
        nv = 0;
        for (int i = 0; i < 90; i++) begin
            if (valid_b) begin
                nv++;
                check("b_score_bcd", 64'(sbcd_b), 64'(to_bcd(score_b)));
                check("b_high_bcd", 64'(hbcd_b), 64'(to_bcd(high_b)));
            end
            step(1);
        end
        check("tick_force_single_valid", 64'(nv), 64'd1);

        step(3);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Converts the running score and stored high score from binary to six BCD digits and drives the six seven-segment displays. It sits directly downstream of the score keeper, sampling its `score` and `highScore` outputs. Conversion is a multi-cycle shift-add-3 (double dabble) engine, run at a fixed refresh rate or on request. The digits shown on the displays are selected from either value by a display-select input.

## Interface
- `CLOCK_FREQUENCY`, 25000000: system clock rate in Hz.
- `REFRESH_HZ`, 20: automatic conversion rate; tick period P = CLOCK_FREQUENCY/REFRESH_HZ cycles.

Ports:
- `Clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `score`  in  32  current score, unsigned binary.
- `highScore`  in  32  high score, unsigned binary.
- `showHigh`  in  1  0 = display score, 1 = display high score.
- `forceUpdate`  in  1  single-cycle conversion request.
- `scoreBCD`  out  24  six BCD digits of score; [23:20] is the most significant digit.
- `highBCD`  out  24  six BCD digits of high score, same layout.
- `HEX0`..`HEX5`  out  7 each  active-low segments; bit 0 = a … bit 6 = g; HEX0 is the least significant digit.
- `busy`  out  1  conversion in progress.
- `valid`  out  1  one-cycle pulse when new BCD values are written.

## Operation
- Tick counter: loads P−1 and counts down every cycle; it emits a tick at 0 and reloads. The counter runs regardless of state.
- Pending flag: set by `forceUpdate` or by a tick. It is cleared when the FSM leaves IDLE.
  - A tick arriving while busy is dropped.
  - A `forceUpdate` arriving while busy is held as pending.
  - A simultaneous tick and `forceUpdate` produce one conversion.
- FSM states:
  - IDLE: if pending, snapshot `score` and `highScore`, go to LOAD_S.
  - LOAD_S: saturate the score snapshot to 999999 if it is >999999. Load bits [19:0] into the shift register and clear the 24-bit BCD accumulator.
  - SHIFT_S (20 cycles): each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1.
  - LOAD_H, then SHIFT_H (20 cycles): same sequence on the high score.
  - DONE: write `scoreBCD` and `highBCD` together, pulse `valid`, return to IDLE.
- The two BCD outputs always update in the same cycle and never show a partial result.
- `busy` = 1 in every state except IDLE.
- Seven-segment encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- HEX registers encode the BCD value selected by `showHigh`.
- Reset values: BCD outputs 0; `busy`/`valid` 0; pending 0; counter P−1; FSM in IDLE; HEX0..HEX5 = 1000000 (see Configuration for the blanking case).
- Reset asserted mid-conversion aborts the conversion: no `valid` pulse, and all outputs return to reset values.

## Timing
- Request seen in IDLE at cycle T: LOAD_S at T+1, SHIFT_S at T+2..T+21, LOAD_H at T+22, SHIFT_H at T+23..T+42, DONE at T+43.
- New BCD values and `valid` = 1 are visible from T+44; `valid` lasts exactly one cycle.
- `busy` is high from T+1 through T+43.
- HEX outputs reflect a BCD change at T+45.
- HEX outputs reflect a `showHigh` change one cycle after the change; this needs no conversion.
- A `forceUpdate` held pending during busy starts the next conversion with IDLE at T+44 and LOAD_S at T+45.
- Inputs are sampled only in the IDLE request cycle; later changes do not affect a conversion in flight.

## Configuration
- `SCORE_DISPLAY_LEADING_BLANK_EN` defined:
  - Leading zero digits from HEX5 downward drive 1111111 (blank).
  - HEX0 always shows its digit, including 0.
  - At reset, HEX5..HEX1 = 1111111 and HEX0 = 1000000.
- Undefined: all six digits always display, including leading zeros.
- The BCD outputs are identical in both builds.

## Test plan
- Reset: hold `reset`=0 mid-conversion → `busy`=0, `valid`=0, BCD=0, HEX all 1000000 (macro off); no `valid` pulse after release.
- Basic conversion: `score`=123456, `highScore`=42, pulse `forceUpdate` at T → `valid` at T+44 with `scoreBCD`=24'h123456 and `highBCD`=24'h000042. With `showHigh`=0, HEX5..HEX0 show 1,2,3,4,5,6 at T+45.
- Saturation: `score`=1000000 → 24'h999999; `score`=32'hFFFFFFFF → 24'h999999; `score`=999999 → 24'h999999; `score`=0 → 24'h000000.
- Display select: after conversion, toggle `showHigh` 0→1 → HEX shows 000042 the next cycle; `busy` stays 0.
- Request collisions: `CLOCK_FREQUENCY`=100, `REFRESH_HZ`=10 (P=10) → ticks during busy are dropped. A `forceUpdate` at T+10 causes LOAD_S at T+45; a simultaneous tick and `forceUpdate` in IDLE give exactly one `valid`.
- Blanking build: macro defined, `highScore`=42, `showHigh`=1 → HEX5..HEX2 = 1111111, HEX1 = 0011001, HEX0 = 0100100. For a value of 0, HEX0 = 1000000.
